gray_conv_arbiter: RTL and testbench



---
 rtl/gray_conv_arbiter.sv | 100 ++++++++++
 tb/tb_gray_conv_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester round-robin binary-to-Gray converter
//
// Purpose:
//   Two requesters share one binary-to-Gray conversion path. Round-robin
//   arbitration picks the requester, and the result is held in a single
//   output register until the consumer takes it (valid/ready handshake).
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   req0/bin0   in   requester 0 request and binary word
//   gnt0        out  requester 0 accepted this cycle (combinational)
//   req1/bin1   in   requester 1 request and binary word
//   gnt1        out  requester 1 accepted this cycle (combinational)
//   gray_out    out  registered Gray result
//   gray_id     out  requester that produced gray_out
//   gray_valid  out  gray_out/gray_id hold a result
//   out_ready   in   consumer takes gray_out this cycle

module gray_conv_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] bin0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [WIDTH-1:0] bin1,
  output logic             gnt1,
  output logic [WIDTH-1:0] gray_out,
  output logic             gray_id,
  output logic             gray_valid,
  input  logic             out_ready
);

  // rr_ptr names the requester that wins when both request together.
  logic             rr_ptr;
  logic             can_accept;
  logic [WIDTH-1:0] gray0;
  logic [WIDTH-1:0] gray1;

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign gray0 = to_gray(bin0);
  assign gray1 = to_gray(bin1);

  // One output slot and no skid buffer: a new word may enter only when the
  // slot is empty or is being drained in this same cycle.
  assign can_accept = !gray_valid || out_ready;

  // Grants are gated by rst so nothing is accepted while reset is held,
  // even though the registers already read as cleared.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && can_accept) begin
      if (req0 && req1) begin
        gnt0 = (rr_ptr == 1'b0);
        gnt1 = (rr_ptr == 1'b1);
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (gnt0) begin
      rr_ptr <= 1'b1;
    end else if (gnt1) begin
      rr_ptr <= 1'b0;
    end
  end

  // A grant in the same cycle as a drain replaces the output back-to-back,
  // so gray_valid stays high at full throughput.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_out   <= '0;
      gray_id    <= 1'b0;
      gray_valid <= 1'b0;
    end else if (gnt0) begin
      gray_out   <= gray0;
      gray_id    <= 1'b0;
      gray_valid <= 1'b1;
    end else if (gnt1) begin
      gray_out   <= gray1;
      gray_id    <= 1'b1;
      gray_valid <= 1'b1;
    end else if (out_ready) begin
      gray_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb/tb_gray_conv_arbiter.sv - self-checking bench for gray_conv_arbiter
module tb_gray_conv_arbiter;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         req0;
  logic [W-1:0] bin0;
  logic         gnt0;
  logic         req1;
  logic [W-1:0] bin1;
  logic         gnt1;
  logic [W-1:0] gray_out;
  logic         gray_id;
  logic         gray_valid;
  logic         out_ready;

  int total = 0;
  int bad   = 0;

  logic [W:0] sbq[$];

  gray_conv_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0       (req0),
    .bin0       (bin0),
    .gnt0       (gnt0),
    .req1       (req1),
    .bin1       (bin1),
    .gnt1       (gnt1),
    .gray_out   (gray_out),
    .gray_id    (gray_id),
    .gray_valid (gray_valid),
    .out_ready  (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_gray(input logic [W-1:0] b);
    logic [W-1:0] g;
    g[W-1] = b[W-1];
    for (int i = 0; i < W - 1; i++) g[i] = b[i+1] ^ b[i];
    return g;
  endfunction

  // Scoreboard: expected {id, gray} pushed when a grant is observed,
  // popped and compared when the consumer takes the output.
  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
    end else begin
      if (gray_valid && out_ready) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got id=%0d gray=%b with nothing expected", gray_id, gray_out);
        end else begin
          logic [W:0] e;
          e = sbq.pop_front();
          if ({gray_id, gray_out} !== e) begin
            bad++;
            $display("FAIL sb_output: got id=%0d gray=%b want id=%0d gray=%b",
                     gray_id, gray_out, e[W], e[W-1:0]);
          end
        end
      end
      if (gnt0 && gnt1) begin
        total++;
        bad++;
        $display("FAIL gnt_onehot: gnt0=%b gnt1=%b both high", gnt0, gnt1);
      end
      if (gnt0) sbq.push_back({1'b0, ref_gray(bin0)});
      if (gnt1) sbq.push_back({1'b1, ref_gray(bin1)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; bin0 = '0; bin1 = '0; out_ready = 1'b0;
    #3;
    total++;
    if ({gray_valid, gray_id, gray_out} !== {1'b0, 1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b id=%b g=%b want 0 0 0000", gray_valid, gray_id, gray_out);
    end
    req0 = 1'b1; req1 = 1'b1; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b00) begin
      bad++;
      $display("FAIL reset_gnt: got gnt0=%b gnt1=%b want 0 0", gnt0, gnt1);
    end
    tick();
    tick();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_single();
    req0 = 1'b1; bin0 = 4'b0110; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL single_gnt: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
    tick();
    req0 = 1'b0;
    total++;
    if ({gray_valid, gray_id, gray_out} !== {1'b1, 1'b0, 4'b0101}) begin
      bad++;
      $display("FAIL single_out: got v=%b id=%b g=%b want 1 0 0101", gray_valid, gray_id, gray_out);
    end
    tick();
    total++;
    if (gray_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drain: got valid=%b want 0", gray_valid);
    end
  endtask

  task automatic test_stall();
    req1 = 1'b1; bin1 = 4'b0011; out_ready = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b01) begin
      bad++;
      $display("FAIL stall_gnt1: got gnt0=%b gnt1=%b want 0 1", gnt0, gnt1);
    end
    tick();
    req1 = 1'b0; req0 = 1'b1; bin0 = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({gray_valid, gray_id, gray_out, gnt0, gnt1} !== {1'b1, 1'b1, 4'b0010, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold%0d: got v=%b id=%b g=%b gnt0=%b gnt1=%b want 1 1 0010 0 0",
                 i, gray_valid, gray_id, gray_out, gnt0, gnt1);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (gnt0 !== 1'b1) begin
      bad++;
      $display("FAIL stall_release_gnt: got gnt0=%b want 1", gnt0);
    end
    tick();
    req0 = 1'b0;
    total++;
    if ({gray_valid, gray_id, gray_out} !== {1'b1, 1'b0, 4'b0111}) begin
      bad++;
      $display("FAIL stall_next_out: got v=%b id=%b g=%b want 1 0 0111", gray_valid, gray_id, gray_out);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] b;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = W'(i);
      req0 = 1'b1; bin0 = b;
      #1;
      total++;
      if (gnt0 !== 1'b1) begin
        bad++;
        $display("FAIL sweep_gnt%0d: got gnt0=%b want 1", i, gnt0);
      end
      tick();
      total++;
      if ({gray_valid, gray_out} !== {1'b1, ref_gray(b)}) begin
        bad++;
        $display("FAIL sweep_out%0d: got v=%b g=%b want 1 %b", i, gray_valid, gray_out, ref_gray(b));
      end
    end
    req0 = 1'b0;
  endtask

  task automatic test_reset_midop();
    // gray_valid=1 and rr_ptr=1 after the last sweep grant (requester 0)
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({gray_valid, gray_out} !== {1'b0, 4'b0000}) begin
      bad++;
      $display("FAIL midreset_async: got v=%b g=%b want 0 0000", gray_valid, gray_out);
    end
    tick();
    rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; bin0 = 4'b1011; bin1 = 4'b1111; out_ready = 1'b1;
    #1;
    total++;
    if ({gnt0, gnt1} !== 2'b10) begin
      bad++;
      $display("FAIL midreset_first_gnt: got gnt0=%b gnt1=%b want 1 0", gnt0, gnt1);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_g;
    logic         exp_id;
    for (int i = 0; i < 6; i++) begin
      exp_id = (i % 2 == 1);
      total++;
      if ({gnt0, gnt1} !== {~exp_id, exp_id}) begin
        bad++;
        $display("FAIL b2b_gnt%0d: got gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, ~exp_id, exp_id);
      end
      tick();
      exp_g = exp_id ? 4'b1000 : 4'b1110;
      total++;
      if ({gray_valid, gray_id, gray_out} !== {1'b1, exp_id, exp_g}) begin
        bad++;
        $display("FAIL b2b_out%0d: got v=%b id=%b g=%b want 1 %b %b",
                 i, gray_valid, gray_id, gray_out, exp_id, exp_g);
      end
      #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (gray_valid !== 1'b0 || sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got valid=%b pending=%0d want 0 0", gray_valid, sbq.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_sweep();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
